eab_pipe: RTL and testbench
===========================

// Module: eab_pipe
// PURPOSE
//  Parametrised, registered effective-address generator for the LC-3 datapath.
//  Computes base (Ra or PC) + sign-extended IR offset (off11/off9/off6/none).
//  Optional indirect mode (LDI/STI) fetches the pointer word from memory.
//  Valid/ready handshakes on input and output; a req/ack port to memory.
// PARAMETERS
//  DATA_W    16  address/data width; legal range 12..64; offsets sign-extend to DATA_W
//  IR_W      11  width of the ir offset field; fixed by LC-3 encoding, must be 11
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       request present
//  in_ready   out  1       block accepts request this cycle
//  ir         in   IR_W    IR[10:0] offset field
//  ra         in   DATA_W  base register value
//  pc         in   DATA_W  program counter
//  sel_eab1   in   1       1: base=ra, 0: base=pc
//  sel_eab2   in   2       11: sext(ir[10:0]), 10: sext(ir[8:0]), 01: sext(ir[5:0]), 00: 0
//  indirect   in   1       1: result = mem[base+offset]
//  mem_req    out  1       memory read request (indirect only)
//  mem_addr   out  DATA_W  address of pointer word
//  mem_ack    in   1       mem_data valid this cycle
//  mem_data   in   DATA_W  pointer word returned by memory
//  out_valid  out  1       eab_out valid
//  out_ready  in   1       consumer takes eab_out this cycle
//  eab_out    out  DATA_W  final effective address
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; out_valid=0, mem_req=0, eab_out=0, mem_addr=0, busy=0.
//  Arithmetic: sum = base + offset, modulo 2^DATA_W (carry dropped, no flag).
//  Inputs sampled only at the accept edge (in_valid & in_ready); later changes ignored.
//  FSM states: IDLE, MEM, OUT.
//   IDLE: in_ready=1. On accept: addr_q<=sum; go MEM if indirect, else OUT.
//   MEM : mem_req=1, mem_addr=addr_q (stable). mem_ack may arrive in any MEM
//         cycle, including the first. On mem_ack: addr_q<=mem_data; go OUT.
//         in_ready=0.
//   OUT : out_valid=1, eab_out=addr_q (held stable while out_ready=0).
//         in_ready = out_ready (combinational). out_ready & !in_valid -> IDLE.
//         out_ready & in_valid: new request accepted on the same edge -> MEM or OUT
//         as above (back-to-back, 1 result per cycle in direct mode).
//  Latency: direct, out_valid the cycle after accept. Indirect, out_valid the cycle
//   after mem_ack.
//  mem_ack outside MEM is ignored, including a stale ack after reset.
//  mem_req deasserts on the edge where mem_ack is taken.
//  Reset in any state aborts the operation. No output pulse follows; no request
//   is retained.
//  mem_addr and eab_out are driven from registers only; no comb path from ir/ra/pc.
// TESTING
//  1 Direct off9: pc=0x3000, sel_eab1=0, sel_eab2=10, ir[8:0]=0x1FF, accept
//    -> next cycle out_valid=1, eab_out=0x2FFF.
//  2 Direct off6: ra=0x0010, sel_eab1=1, sel_eab2=01, ir[5:0]=0x20
//    -> eab_out=0xFFF0. With sel_eab2=00 -> eab_out=0x0010.
//  3 Wrap: pc=0xFFFF, sel_eab2=11, ir=0x001 -> eab_out=0x0000.
//    With DATA_W=32, pc=0xFFFFFFFF -> eab_out=0x0.
//  4 Indirect: pc=0x3000, off9=5, indirect=1 -> mem_req=1, mem_addr=0x3005.
//    mem_ack 3 cycles later with mem_data=0x4000 -> next cycle eab_out=0x4000.
//  5 Backpressure/throughput: hold out_ready=0 for 4 cycles -> eab_out held,
//    in_ready=0. Then out_ready=1 with 3 back-to-back direct requests
//    -> 3 results on 3 consecutive cycles.
//  6 Reset during MEM, then a stray mem_ack after reset -> stays IDLE, out_valid=0,
//    mem_req=0. Next request completes normally.

Source files
------------

// File: rtl/eab_pipe.sv
// Registered LC-3 effective-address generator: base + sign-extended IR offset,
// with an optional indirect pointer fetch over a req/ack memory port.
module eab_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IR_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [DATA_W-1:0] ra_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              sel_eab1_i,
    input  logic [1:0]        sel_eab2_i,
    input  logic              indirect_i,
    output logic              mem_req_o,
    output logic [DATA_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] eab_out_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StMem, StOut} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] base, offset, sum;
    logic              accept;

    assign base = sel_eab1_i ? ra_i : pc_i;

    always_comb begin
        offset = '0;
        unique case (sel_eab2_i)
            2'b11:   offset = {{(DATA_W-11){ir_i[10]}}, ir_i[10:0]};
            2'b10:   offset = {{(DATA_W-9){ir_i[8]}}, ir_i[8:0]};
            2'b01:   offset = {{(DATA_W-6){ir_i[5]}}, ir_i[5:0]};
            default: offset = '0;
        endcase
    end

    // Carry out of the top bit is intentionally dropped.
    assign sum    = base + offset;
    assign accept = in_valid_i & in_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = sum;
                    state_d = indirect_i ? StMem : StOut;
                end
            end
            StMem: begin
                if (mem_ack_i) begin
                    addr_d  = mem_data_i;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (accept) begin
                    addr_d  = sum;
                    state_d = indirect_i ? StMem : StOut;
                end else if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        mem_req_o   = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle:  in_ready_o = 1'b1;
            StMem:   mem_req_o = 1'b1;
            StOut: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    assign busy_o     = (state_q != StIdle);
    assign mem_addr_o = addr_q;
    assign eab_out_o  = addr_q;

endmodule

// File: tb/tb_eab_pipe.sv
// Self-checking bench for eab_pipe: 16-bit and 32-bit instances driven in lockstep
// from a vector table, plus directed indirect, backpressure and reset sequences.
module tb_eab_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [10:0] ir;
    logic [15:0] ra, pc, mem_data;
    logic [31:0] ra32, pc32, mem_data32;
    logic        sel1;
    logic [1:0]  sel2;
    logic        indirect;
    logic        mem_ack;
    logic        out_ready;

    logic        in_ready, mem_req, out_valid, busy;
    logic [15:0] mem_addr, eab_out;
    logic        in_ready32, mem_req32, out_valid32, busy32;
    logic [31:0] mem_addr32, eab_out32;

    int checks = 0;
    int errors = 0;

    eab_pipe #(.DATA_W(16), .IR_W(11)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ir_i(ir), .ra_i(ra), .pc_i(pc), .sel_eab1_i(sel1), .sel_eab2_i(sel2),
        .indirect_i(indirect), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_data_i(mem_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .eab_out_o(eab_out), .busy_o(busy)
    );

    eab_pipe #(.DATA_W(32), .IR_W(11)) dut32 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .ir_i(ir), .ra_i(ra32), .pc_i(pc32), .sel_eab1_i(sel1), .sel_eab2_i(sel2),
        .indirect_i(indirect), .mem_req_o(mem_req32), .mem_addr_o(mem_addr32),
        .mem_ack_i(mem_ack), .mem_data_i(mem_data32), .out_valid_o(out_valid32),
        .out_ready_i(out_ready), .eab_out_o(eab_out32), .busy_o(busy32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [10:0] ir;
        logic [15:0] ra;
        logic [15:0] pc;
        logic [31:0] ra32;
        logic [31:0] pc32;
        logic        sel1;
        logic [1:0]  sel2;
        logic [15:0] exp;
        logic [31:0] exp32;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] f_ir, input logic [15:0] f_ra,
                         input logic [15:0] f_pc, input logic f_sel1,
                         input logic [1:0] f_sel2, input logic f_ind);
        in_valid = 1'b1;
        ir       = f_ir;
        ra       = f_ra;
        pc       = f_pc;
        ra32     = {16'h0, f_ra};
        pc32     = {16'h0, f_pc};
        sel1     = f_sel1;
        sel2     = f_sel2;
        indirect = f_ind;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; ir = '0; ra = '0; pc = '0; ra32 = '0; pc32 = '0;
        sel1 = 1'b0; sel2 = 2'b00; indirect = 1'b0;
        mem_ack = 1'b0; mem_data = '0; mem_data32 = '0; out_ready = 1'b1;

        //               ir      ra       pc       ra32          pc32          s1  s2     exp      exp32
        vecs[0] = '{11'h1FF, 16'h0000, 16'h3000, 32'h0,        32'h3000,     0, 2'b10, 16'h2FFF, 32'h2FFF};
        vecs[1] = '{11'h020, 16'h0010, 16'h0000, 32'h10,       32'h0,        1, 2'b01, 16'hFFF0, 32'hFFFFFFF0};
        vecs[2] = '{11'h020, 16'h0010, 16'h0000, 32'h10,       32'h0,        1, 2'b00, 16'h0010, 32'h10};
        vecs[3] = '{11'h001, 16'h0000, 16'hFFFF, 32'h0,        32'hFFFFFFFF, 0, 2'b11, 16'h0000, 32'h0};
        vecs[4] = '{11'h400, 16'h1000, 16'h0000, 32'h1000,     32'h0,        1, 2'b11, 16'h0C00, 32'hC00};
        vecs[5] = '{11'h6FF, 16'h0000, 16'h3000, 32'h0,        32'h3000,     0, 2'b10, 16'h30FF, 32'h30FF};
        vecs[6] = '{11'h7DF, 16'h0001, 16'h0000, 32'h1,        32'h0,        1, 2'b01, 16'h0020, 32'h20};
        vecs[7] = '{11'h3FF, 16'h0000, 16'h0001, 32'h0,        32'h1,        0, 2'b11, 16'h0400, 32'h400};
        vecs[8] = '{11'h100, 16'h5678, 16'h0000, 32'h12345678, 32'h0,        1, 2'b10, 16'h5578, 32'h12345578};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst busy", {63'h0, busy}, 64'h0);
        chk("rst eab_out", {48'h0, eab_out}, 64'h0);
        chk("rst mem_addr", {48'h0, mem_addr}, 64'h0);
        chk("rst busy32", {63'h0, busy32}, 64'h0);
        rst = 1'b0;

        // Direct table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ir = vecs[i].ir; ra = vecs[i].ra; pc = vecs[i].pc;
            ra32 = vecs[i].ra32; pc32 = vecs[i].pc32;
            sel1 = vecs[i].sel1; sel2 = vecs[i].sel2; indirect = 1'b0;
            #1;
            chk($sformatf("vec%0d in_ready", i), {63'h0, in_ready}, 64'h1);
            @(negedge clk);
            in_valid = 1'b0;
            ra = 16'hDEAD; pc = 16'hBEEF;
            #1;
            chk($sformatf("vec%0d out_valid", i), {63'h0, out_valid}, 64'h1);
            chk($sformatf("vec%0d eab_out", i), {48'h0, eab_out}, {48'h0, vecs[i].exp});
            chk($sformatf("vec%0d eab_out32", i), {32'h0, eab_out32}, {32'h0, vecs[i].exp32});
            chk($sformatf("vec%0d out_valid32", i), {63'h0, out_valid32}, 64'h1);
        end

        // Indirect, ack three cycles into MEM
        @(negedge clk);
        drive(11'h005, 16'h0, 16'h3000, 1'b0, 2'b10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; pc = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ind c%0d mem_req", c), {63'h0, mem_req}, 64'h1);
            chk($sformatf("ind c%0d mem_addr", c), {48'h0, mem_addr}, 64'h3005);
            chk($sformatf("ind c%0d in_ready", c), {63'h0, in_ready}, 64'h0);
            chk($sformatf("ind c%0d out_valid", c), {63'h0, out_valid}, 64'h0);
            if (c < 2) @(negedge clk);
        end
        chk("ind mem_addr32", {32'h0, mem_addr32}, 64'h3005);
        mem_ack = 1'b1; mem_data = 16'h4000; mem_data32 = 32'h4000;
        @(negedge clk);
        mem_ack = 1'b0; mem_data = 16'h0;
        #1;
        chk("ind out_valid", {63'h0, out_valid}, 64'h1);
        chk("ind eab_out", {48'h0, eab_out}, 64'h4000);
        chk("ind mem_req off", {63'h0, mem_req}, 64'h0);
        chk("ind mem_req32 off", {63'h0, mem_req32}, 64'h0);

        // Indirect, ack in the first MEM cycle
        @(negedge clk);
        drive(11'h3F0, 16'h0100, 16'h0, 1'b1, 2'b01, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ind1 mem_addr", {48'h0, mem_addr}, 64'h00F0);
        mem_ack = 1'b1; mem_data = 16'h1234; mem_data32 = 32'h1234;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("ind1 out_valid", {63'h0, out_valid}, 64'h1);
        chk("ind1 eab_out", {48'h0, eab_out}, 64'h1234);

        // Backpressure then three back-to-back direct requests
        @(negedge clk);
        out_ready = 1'b0;
        drive(11'h0, 16'h0100, 16'h0, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        drive(11'h0, 16'h0200, 16'h0, 1'b1, 2'b00, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp c%0d out_valid", c), {63'h0, out_valid}, 64'h1);
            chk($sformatf("bp c%0d eab_out", c), {48'h0, eab_out}, 64'h0100);
            chk($sformatf("bp c%0d in_ready", c), {63'h0, in_ready}, 64'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {63'h0, in_ready}, 64'h1);
        chk("bp release in_ready32", {63'h0, in_ready32}, 64'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(11'h0, 16'h0300 + 16'(k * 16'h100), 16'h0, 1'b1, 2'b00, 1'b0);
            if (k == 2) in_valid = 1'b0;
            #1;
            chk($sformatf("b2b r%0d out_valid", k), {63'h0, out_valid}, 64'h1);
            chk($sformatf("b2b r%0d eab_out", k), {48'h0, eab_out},
                {48'h0, 16'h0200 + 16'(k * 16'h100)});
        end
        @(negedge clk);
        #1;
        chk("b2b drain out_valid", {63'h0, out_valid}, 64'h0);

        // Reset during MEM, stray ack across and after reset
        drive(11'h010, 16'h0, 16'h5000, 1'b0, 2'b10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rmem busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        #1;
        chk("rmem async busy", {63'h0, busy}, 64'h0);
        chk("rmem async mem_req", {63'h0, mem_req}, 64'h0);
        chk("rmem async eab_out", {48'h0, eab_out}, 64'h0);
        mem_ack = 1'b1; mem_data = 16'h7777; mem_data32 = 32'h7777;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stray c%0d out_valid", c), {63'h0, out_valid}, 64'h0);
            chk($sformatf("stray c%0d mem_req", c), {63'h0, mem_req}, 64'h0);
            chk($sformatf("stray c%0d busy", c), {63'h0, busy}, 64'h0);
        end
        mem_ack = 1'b0;
        @(negedge clk);
        drive(11'h002, 16'h0, 16'h5000, 1'b0, 2'b11, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post-rst out_valid", {63'h0, out_valid}, 64'h1);
        chk("post-rst eab_out", {48'h0, eab_out}, 64'h5002);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
